branch_resolve_unit: RTL and testbench

//  Execute-stage branch resolver directly downstream of the comparator.
//  - Accepts one control-flow op per handshake and drives the comparator.
//  - Consumes gt/lt/eq to decide taken/not-taken and computes the target.
//  - Checks the result against the fetch prediction and issues a one-cycle redirect on mispredict.
//  - Holds one result in an output register until writeback accepts it.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/comparator.sv | 19 +
 rtl/branch_resolve_unit.sv | 155 +++++++++++++++
 tb/tb_branch_resolve_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the execute-stage branch resolver.
package riscv_pkg;

  typedef enum logic [1:0] {
    OpNone   = 2'b00,
    OpBranch = 2'b01,
    OpJal    = 2'b10,
    OpJalr   = 2'b11
  } bru_op_t;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } bru_state_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int unsigned ILEN_BYTES = 4;

endpackage

// File: rtl/comparator.sv
// N-bit magnitude/equality comparator; signed_i selects two's-complement ordering.
module comparator #(
  parameter int unsigned N = 64
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         signed_i,
  output logic         gt_o,
  output logic         lt_o,
  output logic         eq_o
);

  always_comb begin
    eq_o = (a_i == b_i);
    lt_o = signed_i ? ($signed(a_i) < $signed(b_i)) : (a_i < b_i);
    gt_o = ~lt_o & ~eq_o;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: decides direction/target, flags mispredicts, holds one result.
// Optional statistics counters are built only when BRU_STATS_EN is defined.
module branch_resolve_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned PC_W  = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  bru_op_t          in_op_i,
  input  logic [2:0]       in_funct3_i,
  input  logic [XLEN-1:0]  in_rs1_i,
  input  logic [XLEN-1:0]  in_rs2_i,
  input  logic [PC_W-1:0]  in_pc_i,
  input  logic [PC_W-1:0]  in_imm_i,
  input  logic             in_pred_taken_i,
  input  logic [PC_W-1:0]  in_pred_target_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_taken_o,
  output logic [PC_W-1:0]  out_link_o,
  output logic             out_misalign_o,
  output logic             redirect_valid_o,
  output logic [PC_W-1:0]  redirect_pc_o,
  input  logic             flush_i,
  output logic [CNT_W-1:0] stat_branches_o,
  output logic [CNT_W-1:0] stat_mispred_o
);

  bru_state_t      state_q, state_d;
  logic            redirect_valid_q;
  logic [PC_W-1:0] redirect_pc_q;
  logic            out_taken_q, out_misalign_q;
  logic [PC_W-1:0] out_link_q;

  logic            cmp_gt, cmp_lt, cmp_eq;
  logic            accept, cond_taken, taken, misalign, mispredict, redirect_d;
  logic [PC_W-1:0] rs1_pc, link, jalr_sum, target, next_pc;

  comparator #(
    .N(XLEN)
  ) u_cmp (
    .a_i     (in_rs1_i),
    .b_i     (in_rs2_i),
    .signed_i(~in_funct3_i[1]),
    .gt_o    (cmp_gt),
    .lt_o    (cmp_lt),
    .eq_o    (cmp_eq)
  );

  assign in_ready_o = ((state_q == StEmpty) | out_ready_i) & ~redirect_valid_q & ~flush_i;
  assign accept     = in_valid_i & in_ready_o;

  always_comb begin
    cond_taken = 1'b0;
    case (in_funct3_i)
      F3_BEQ:           cond_taken = cmp_eq;
      F3_BNE:           cond_taken = ~cmp_eq;
      F3_BLT, F3_BLTU:  cond_taken = cmp_lt;
      F3_BGE, F3_BGEU:  cond_taken = cmp_gt | cmp_eq;
      default:          cond_taken = 1'b0;
    endcase

    rs1_pc   = PC_W'(in_rs1_i);
    link     = in_pc_i + PC_W'(ILEN_BYTES);
    jalr_sum = rs1_pc + in_imm_i;
    target   = in_pc_i + in_imm_i;
    taken    = 1'b0;
    unique case (in_op_i)
      OpNone:   taken = 1'b0;
      OpBranch: taken = cond_taken;
      OpJal:    taken = 1'b1;
      OpJalr: begin
        taken  = 1'b1;
        target = {jalr_sum[PC_W-1:1], 1'b0};
      end
    endcase

    misalign   = taken & target[1];
    next_pc    = taken ? target : link;
    mispredict = (taken != in_pred_taken_i) | (taken & (target != in_pred_target_i));
    // Misaligned targets trap downstream, so fetch is not redirected for them.
    redirect_d = accept & (in_op_i != OpNone) & mispredict & ~misalign;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = StEmpty;
    end else if (accept) begin
      state_d = StFull;
    end else if ((state_q == StFull) && out_ready_i) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= StEmpty;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      out_taken_q      <= 1'b0;
      out_misalign_q   <= 1'b0;
      out_link_q       <= '0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_d;
      if (redirect_d) begin
        redirect_pc_q <= next_pc;
      end
      if (accept) begin
        out_taken_q    <= taken;
        out_misalign_q <= misalign;
        out_link_q     <= link;
      end
    end
  end

  assign out_valid_o      = (state_q == StFull);
  assign out_taken_o      = out_taken_q;
  assign out_misalign_o   = out_misalign_q;
  assign out_link_o       = out_link_q;
  assign redirect_valid_o = redirect_valid_q & ~flush_i;
  assign redirect_pc_o    = redirect_pc_q;

`ifdef BRU_STATS_EN
  logic [CNT_W-1:0] stat_branches_q, stat_mispred_q;

  // Both counters saturate; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      if (accept && (in_op_i != OpNone) && !(&stat_branches_q)) begin
        stat_branches_q <= stat_branches_q + 1'b1;
      end
      if (redirect_valid_o && !(&stat_mispred_q)) begin
        stat_mispred_q <= stat_mispred_q + 1'b1;
      end
    end
  end

  assign stat_branches_o = stat_branches_q;
  assign stat_mispred_o  = stat_mispred_q;
`else
  assign stat_branches_o = '0;
  assign stat_mispred_o  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: vector table plus backpressure/flush/reset sequences.
module tb_branch_resolve_unit;
  import riscv_pkg::*;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned PC_W  = 64;
  localparam int unsigned CNT_W = 32;

  typedef struct packed {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] pc;
    logic [63:0] imm;
    logic        pt;
    logic [63:0] ptgt;
    logic        taken;
    logic [63:0] link;
    logic        mis;
    logic        redir;
    logic [63:0] rpc;
  } vec_t;

  typedef struct packed {
    logic        taken;
    logic [63:0] link;
    logic        mis;
    logic        redir;
    logic [63:0] rpc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  bru_op_t          in_op;
  logic [2:0]       in_funct3;
  logic [XLEN-1:0]  in_rs1, in_rs2;
  logic [PC_W-1:0]  in_pc, in_imm, in_pred_target;
  logic             in_pred_taken;
  logic             out_valid, out_ready, out_taken, out_misalign;
  logic [PC_W-1:0]  out_link, redirect_pc;
  logic             redirect_valid, flush;
  logic [CNT_W-1:0] stat_branches, stat_mispred;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t vecs[13];

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .XLEN (XLEN),
    .PC_W (PC_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .in_op_i         (in_op),
    .in_funct3_i     (in_funct3),
    .in_rs1_i        (in_rs1),
    .in_rs2_i        (in_rs2),
    .in_pc_i         (in_pc),
    .in_imm_i        (in_imm),
    .in_pred_taken_i (in_pred_taken),
    .in_pred_target_i(in_pred_target),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_taken_o     (out_taken),
    .out_link_o      (out_link),
    .out_misalign_o  (out_misalign),
    .redirect_valid_o(redirect_valid),
    .redirect_pc_o   (redirect_pc),
    .flush_i         (flush),
    .stat_branches_o (stat_branches),
    .stat_mispred_o  (stat_mispred)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_op          = bru_op_t'(v.op);
    in_funct3      = v.f3;
    in_rs1         = v.rs1;
    in_rs2         = v.rs2;
    in_pc          = v.pc;
    in_imm         = v.imm;
    in_pred_taken  = v.pt;
    in_pred_target = v.ptgt;
  endtask

  function automatic exp_t to_exp(input vec_t v);
    exp_t e;
    e.taken = v.taken;
    e.link  = v.link;
    e.mis   = v.mis;
    e.redir = v.redir;
    e.rpc   = v.rpc;
    return e;
  endfunction

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_taken"}, 64'(out_taken), 64'(e.taken));
    chk({tag, "_link"}, out_link, e.link);
    chk({tag, "_misalign"}, 64'(out_misalign), 64'(e.mis));
  endtask

  // One op through an empty stage with out_ready high; checks the full result and redirect pulse.
  task automatic run_vec(input string tag, input vec_t v);
    exp_t e;
    @(negedge clk);
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    flush     = 1'b0;
    #1;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    if (in_valid && in_ready) sb.push_back(to_exp(v));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check_out(tag, e);
      chk({tag, "_redirect"}, 64'(redirect_valid), 64'(e.redir));
      if (e.redir) begin
        chk({tag, "_redirect_pc"}, redirect_pc, e.rpc);
        chk({tag, "_ready_in_redir"}, 64'(in_ready), 64'd0);
      end
    end
    @(negedge clk);
    #1;
    chk({tag, "_redirect_end"}, 64'(redirect_valid), 64'd0);
    chk({tag, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    exp_t e;
    vec_t va, vb;
    // op, f3, rs1, rs2, pc, imm, pred_taken, pred_target, taken, link, misalign, redir, redir_pc
    vecs[0]  = '{2'b01, 3'b000, 64'd5, 64'd5, 64'h100, 64'h20, 1'b0, 64'h0,
                 1'b1, 64'h104, 1'b0, 1'b1, 64'h120};
    vecs[1]  = '{2'b01, 3'b100, -64'sd128, -64'sd1, 64'h200, 64'h40, 1'b1, 64'h240,
                 1'b1, 64'h204, 1'b0, 1'b0, 64'h0};
    vecs[2]  = '{2'b01, 3'b110, 64'hFFFF_FFFF_FFFF_FF80, 64'd1, 64'h300, 64'h10, 1'b1, 64'h310,
                 1'b0, 64'h304, 1'b0, 1'b1, 64'h304};
    vecs[3]  = '{2'b11, 3'b000, 64'h1003, 64'd0, 64'h400, 64'h0, 1'b0, 64'h0,
                 1'b1, 64'h404, 1'b1, 1'b0, 64'h0};
    vecs[4]  = '{2'b01, 3'b001, 64'd3, 64'd3, 64'h500, 64'h8, 1'b0, 64'h0,
                 1'b0, 64'h504, 1'b0, 1'b0, 64'h0};
    vecs[5]  = '{2'b01, 3'b101, -64'sd1, 64'd1, 64'h600, 64'h8, 1'b0, 64'h0,
                 1'b0, 64'h604, 1'b0, 1'b0, 64'h0};
    vecs[6]  = '{2'b01, 3'b111, -64'sd1, 64'd1, 64'h700, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 64'h6F0,
                 1'b1, 64'h704, 1'b0, 1'b0, 64'h0};
    vecs[7]  = '{2'b10, 3'b000, 64'd0, 64'd0, 64'h800, 64'h100, 1'b1, 64'h904,
                 1'b1, 64'h804, 1'b0, 1'b1, 64'h900};
    vecs[8]  = '{2'b01, 3'b010, 64'd7, 64'd7, 64'h900, 64'h20, 1'b1, 64'h920,
                 1'b0, 64'h904, 1'b0, 1'b1, 64'h904};
    vecs[9]  = '{2'b00, 3'b000, 64'd0, 64'd0, 64'hA00, 64'h40, 1'b1, 64'hA40,
                 1'b0, 64'hA04, 1'b0, 1'b0, 64'h0};
    vecs[10] = '{2'b10, 3'b000, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 1'b1, 64'h10,
                 1'b1, 64'hFFFF_FFFF_FFFF_FFF4, 1'b0, 1'b0, 64'h0};
    vecs[11] = '{2'b01, 3'b100, 64'd1, 64'd2, 64'h1000, 64'h6, 1'b0, 64'h0,
                 1'b1, 64'h1004, 1'b1, 1'b0, 64'h0};
    vecs[12] = '{2'b11, 3'b000, 64'h2001, 64'd0, 64'h1100, 64'h10, 1'b1, 64'h2010,
                 1'b1, 64'h1104, 1'b0, 1'b0, 64'h0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    drive(vecs[9]);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_taken", 64'(out_taken), 64'd0);
    chk("rst_out_misalign", 64'(out_misalign), 64'd0);
    chk("rst_redirect", 64'(redirect_valid), 64'd0);
    chk("rst_out_link", out_link, 64'd0);
    chk("rst_redirect_pc", redirect_pc, 64'd0);
    chk("rst_stat_br", 64'(stat_branches), 64'd0);
    chk("rst_stat_mp", 64'(stat_mispred), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Backpressure: A held for 3 cycles with B waiting, then back-to-back accept.
    va = '{2'b10, 3'b000, 64'd0, 64'd0, 64'h40, 64'h40, 1'b1, 64'h80,
           1'b1, 64'h44, 1'b0, 1'b0, 64'h0};
    vb = '{2'b01, 3'b001, 64'd1, 64'd2, 64'h80, 64'h8, 1'b1, 64'h88,
           1'b1, 64'h84, 1'b0, 1'b0, 64'h0};
    @(negedge clk);
    drive(va);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1;
    chk("bp_accept_a", 64'(in_ready), 64'd1);
    if (in_valid && in_ready) sb.push_back(to_exp(va));
    @(negedge clk);
    drive(vb);
    #1;
    if (sb.size() > 0) check_out("bp_a", sb[0]);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      chk($sformatf("bp_stall%0d_ready", c), 64'(in_ready), 64'd0);
      chk($sformatf("bp_stall%0d_link", c), out_link, 64'h44);
      chk($sformatf("bp_stall%0d_valid", c), 64'(out_valid), 64'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    if (in_valid && in_ready) begin
      if (sb.size() > 0) e = sb.pop_front();
      sb.push_back(to_exp(vb));
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_out("bp_b", e);
    end else begin
      chk("bp_b_sb_nonempty", 64'd0, 64'd1);
    end
    @(negedge clk);
    #1;
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Flush in the redirect cycle: result killed, pulse masked, new op refused.
    @(negedge clk);
    drive(vecs[0]);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1;
    if (in_valid && in_ready) sb.push_back(to_exp(vecs[0]));
    @(negedge clk);
    drive(vecs[1]);
    #1;
    chk("fl_pre_redirect", 64'(redirect_valid), 64'd1);
    flush = 1'b1;
    #1;
    chk("fl_redirect_masked", 64'(redirect_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_redirect_after", 64'(redirect_valid), 64'd0);
    sb.delete();

    // Reset while a mispredicting op is held.
    @(negedge clk);
    drive(vecs[2]);
    in_valid = 1'b1;
    #1;
    if (in_valid && in_ready) sb.push_back(to_exp(vecs[2]));
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mr_out_valid", 64'(out_valid), 64'd0);
    chk("mr_redirect", 64'(redirect_valid), 64'd0);
    chk("mr_out_link", out_link, 64'd0);
    chk("mr_redirect_pc", redirect_pc, 64'd0);
    chk("mr_out_taken", 64'(out_taken), 64'd0);
    sb.delete();

    // Four ops, two of them redirecting.
    run_vec("st0", vecs[0]);
    run_vec("st1", vecs[1]);
    run_vec("st2", vecs[2]);
    run_vec("st3", vecs[4]);
`ifdef BRU_STATS_EN
    chk("stat_branches", 64'(stat_branches), 64'd4);
    chk("stat_mispred", 64'(stat_mispred), 64'd2);
`else
    chk("stat_branches_off", 64'(stat_branches), 64'd0);
    chk("stat_mispred_off", 64'(stat_mispred), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
